// File: rtl/sync_wconv_fifo_if.sv
// Stream bundle for sync_wconv_fifo: write side, read side and status.
// master drives writes and read-ready; slave is the FIFO itself.
interface sync_wconv_fifo_if #(
    parameter int IN_DATA_WIDTH  = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4
);
    localparam int WIDE =
        (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH;
    localparam int NARROW =
        (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? OUT_DATA_WIDTH : IN_DATA_WIDTH;
    localparam int CAT_NUM    = WIDE / NARROW;
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

    logic [IN_DATA_WIDTH-1:0]  data_i;
    logic                      wr_valid_i;
    logic                      wr_ready_o;
    logic                      wr_last_i;
    logic [CAT_NUM-1:0]        wr_keep_i;
    logic [OUT_DATA_WIDTH-1:0] data_o;
    logic                      rd_valid_i;
    logic                      rd_ready_o;
    logic                      rd_last_o;
    logic [CAT_NUM-1:0]        rd_keep_o;
    logic                      empty_o;
    logic                      full_o;
    logic [ADDR_WIDTH:0]       counter;

    modport master (
        output data_i, wr_valid_i, wr_last_i, wr_keep_i, rd_valid_i,
        input  wr_ready_o, data_o, rd_ready_o, rd_last_o, rd_keep_o,
        input  empty_o, full_o, counter
    );

    modport slave (
        input  data_i, wr_valid_i, wr_last_i, wr_keep_i, rd_valid_i,
        output wr_ready_o, data_o, rd_ready_o, rd_last_o, rd_keep_o,
        output empty_o, full_o, counter
    );
endinterface

// File: rtl/sync_wconv_fifo.sv
// Synchronous FIFO with integer-ratio up/down width conversion,
// per-beat last and lane-valid keep qualifiers.
module sync_wconv_fifo #(
    parameter int IN_DATA_WIDTH  = 8,
    parameter int OUT_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter     ORDER          = "LSB"
) (
    input logic              clk,
    input logic              rst,
    sync_wconv_fifo_if.slave bus
);
    localparam int WIDE =
        (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH;
    localparam int NARROW =
        (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? OUT_DATA_WIDTH : IN_DATA_WIDTH;
    localparam int CAT_NUM    = WIDE / NARROW;
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int PW         = ADDR_WIDTH + 1;
    localparam int LW         = (CAT_NUM > 1) ? $clog2(CAT_NUM) : 1;
    localparam int CW         = $clog2(CAT_NUM + 1);
    localparam bit UP         = OUT_DATA_WIDTH > IN_DATA_WIDTH;
    localparam bit DN         = IN_DATA_WIDTH > OUT_DATA_WIDTH;
    localparam bit MSB_FIRST  = (ORDER == "MSB");

    localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LANE_MAX = LW'(CAT_NUM - 1);

    logic [WIDE-1:0]       mem_q [FIFO_DEPTH];
    logic [CW-1:0]         cnt_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [LW-1:0]   rlane_q, rlane_d;
    logic [WIDE-1:0] pack_q, pack_d;

    logic [PW-1:0]         count;
    logic                  empty, full;
    logic                  wr_hs, rd_hs;
    logic                  push, pop, at_end;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [WIDE-1:0]       wr_word, rd_word;
    logic [CW-1:0]         wr_cnt, rd_cnt, keep_cnt;
    logic [CAT_NUM-1:0]    keep;
    int                    rd_shift;

    // Lane 0 is always first in time; ORDER only picks where it lands.
    function automatic logic [LW-1:0] lane_pos(input logic [LW-1:0] l);
        return MSB_FIRST ? LANE_MAX - l : l;
    endfunction

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_P);
    assign wr_hs   = bus.wr_valid_i & ~full;
    assign rd_hs   = bus.rd_valid_i & ~empty;
    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign rd_word = mem_q[rd_addr];
    assign rd_cnt  = cnt_mem_q[rd_addr];

    // Holes below the top keep bit still count as valid lanes.
    always_comb begin
        keep_cnt = CW'(1);
        for (int i = 0; i < CAT_NUM; i++) begin
            if (bus.wr_keep_i[i]) keep_cnt = CW'(i + 1);
        end
    end

    always_comb begin
        wr_word = WIDE'(bus.data_i);
        wr_cnt  = CW'(1);
        if (UP) begin
            wr_word = pack_q
                    | (WIDE'(bus.data_i)
                       << (NARROW * int'(lane_pos(lane_q))));
            wr_cnt  = CW'(lane_q) + CW'(1);
        end else if (DN) begin
            wr_cnt = keep_cnt;
        end
    end

    assign push = UP ? wr_hs & ((lane_q == LANE_MAX) | bus.wr_last_i)
                     : wr_hs;
    assign at_end = DN ? ((CW'(rlane_q) + CW'(1)) == rd_cnt) : 1'b1;
    assign pop    = rd_hs & at_end;

    always_comb begin
        lane_d  = lane_q;
        pack_d  = pack_q;
        rlane_d = rlane_q;
        if (UP && wr_hs) begin
            if (push) begin
                lane_d = '0;
                pack_d = '0;
            end else begin
                lane_d = lane_q + LW'(1);
                pack_d = wr_word;
            end
        end
        if (DN && rd_hs) begin
            rlane_d = at_end ? '0 : rlane_q + LW'(1);
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lane_q   <= '0;
            rlane_q  <= '0;
            pack_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lane_q   <= lane_d;
            rlane_q  <= rlane_d;
            pack_q   <= pack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_addr]      <= wr_word;
            cnt_mem_q[wr_addr]  <= wr_cnt;
            last_mem_q[wr_addr] <= bus.wr_last_i;
        end
    end

    always_comb begin
        keep = '0;
        if (!empty) begin
            if (UP) begin
                for (int i = 0; i < CAT_NUM; i++) begin
                    keep[i] = (CW'(i) < rd_cnt);
                end
            end else begin
                keep = CAT_NUM'(1);
            end
        end
    end

    assign rd_shift = DN ? NARROW * int'(lane_pos(rlane_q)) : 0;

    assign bus.data_o     = OUT_DATA_WIDTH'(rd_word >> rd_shift);
    assign bus.rd_keep_o  = keep;
    assign bus.rd_last_o  = ~empty & last_mem_q[rd_addr] & at_end;
    assign bus.rd_ready_o = ~empty;
    assign bus.wr_ready_o = ~full;
    assign bus.empty_o    = empty;
    assign bus.full_o     = full;
    assign bus.counter    = count;
endmodule
